regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Debug-side reader for the 32x32 register file.
- On a start request it sweeps register indices FIRST_REG..LAST_REG through one spare combinational read port.
- Each value is registered and streamed out as an (index, data) beat over a valid/ready handshake.
- It sits beside the core's register file and feeds the debug/trace link. It never writes the register file.

Parameters:
- FIRST_REG, 0, first register index dumped (0..31).
- LAST_REG, 31, last register index dumped (FIRST_REG..31).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  dump request, sampled in IDLE only.
- abort  input  1  cancel the dump in progress; return to IDLE without done.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the final beat handshakes.
- rf_raddr  output  5  register file read index.
- rf_rdata  input  DATA_W  combinational read data for rf_raddr; x0 reads 0.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_idx  output  5  register index of the current beat.
- out_data  output  DATA_W  register value of the current beat.
- out_last  output  1  final beat of the dump.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state IDLE, idx=FIRST_REG. busy, done, out_valid and out_last are 0. out_idx, out_data and rf_raddr are 0.
- FSM states: IDLE, READ, SEND, FIN.
- IDLE:
  - rf_raddr=0.
  - start=1 -> load idx=FIRST_REG, go to READ.
- READ (one cycle):
  - rf_raddr=idx.
  - At the clock edge, out_data<=rf_rdata and out_idx<=idx. Go to SEND.
- SEND:
  - out_valid=1. out_idx, out_data and out_last stay stable until the handshake.
  - out_last=(idx==LAST_REG).
  - Handshake = out_valid & out_ready.
  - Handshake with idx!=LAST_REG -> idx<=idx+1, go to READ.
  - Handshake with idx==LAST_REG -> go to FIN.
  - No handshake -> stay in SEND.
- FIN: done=1 for exactly one cycle, then IDLE.
- Latency and throughput:
  - start to first out_valid is 2 cycles.
  - With out_ready held high, one beat every 2 cycles.
  - Full dump of 32 registers: 64 cycles plus 1 FIN cycle.
- start while busy: ignored, no queuing.
- start in the same cycle that FIN returns to IDLE: ignored. start is sampled only while in IDLE.
- abort:
  - Any non-IDLE state -> IDLE on the next edge. out_valid drops, no done pulse, idx resets.
  - abort has priority over a simultaneous handshake.
  - abort in IDLE has no effect. Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- rst mid-dump: same as a reset from power-up. No partial done.
- Consistency: no atomic snapshot. Each beat reflects the register contents at its READ cycle; a core write after that cycle is not reflected.
- Index counter: 5-bit. It never wraps past LAST_REG.
- Parameter checks: elaboration fails if LAST_REG<FIRST_REG or LAST_REG>31.

Optional Feature:
- Macro: REGDUMP_CSUM_EN.
- Defined:
  - A DATA_W-bit XOR accumulator clears on start and XORs each handshaked out_data.
  - After the LAST_REG beat, one extra beat is sent with out_idx=5'd31, out_data=accumulator and out_last=1.
  - out_last is 0 on the LAST_REG data beat.
  - FIN follows the checksum handshake.
  - Full dump: 33 beats.
- Not defined: no accumulator, no extra beat. out_last is set on the LAST_REG beat.

Decomposition:
- Package regdump_pkg holds:
  - the state enum (IDLE, READ, SEND, FIN, plus CSUM when enabled);
  - REG_IDX_W=5 and NUM_REGS=32;
  - the default data width of 32.
- Natural sub-module: regdump_csum, the XOR accumulator with clear/enable. It is instantiated only under REGDUMP_CSUM_EN.

Test Plan:
- Preload x1=0x11111111, x5=0xDEADBEEF, others 0. Pulse start, out_ready=1 -> 32 beats with idx 0..31 in order. Beat 0 has data 0, beat 5 has 0xDEADBEEF. out_last on idx 31. done pulses at cycle 65 after start.
- Backpressure: out_ready low for 5 cycles during beat idx=3 -> out_valid, out_idx=3 and out_data stay stable. The sweep resumes at idx 4 with no beat lost or duplicated.
- abort asserted during SEND of idx=10 with out_ready=1 -> no idx 10 handshake counted, busy=0 next cycle, no done. A following start restarts at idx 0.
- FIRST_REG=30, LAST_REG=31 -> exactly 2 beats; out_last on idx 31. start pulsed mid-dump is ignored.
- rst=1 mid-dump at idx 7 -> next cycle all outputs 0 and state IDLE.
- REGDUMP_CSUM_EN, x1=0xF0F0F0F0, x2=0x0F0F0F0F, others 0 -> 33rd beat data 0xFFFFFFFF with out_last=1. The idx 31 beat has out_last=0.

Source files
------------

// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and sizes for the register file dump reader.
// REGDUMP_CSUM_EN adds the CSUM state used for the trailing XOR checksum beat.
package regdump_pkg;

   localparam int unsigned REG_IDX_W  = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned DEF_DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      SEND,
      FIN
`ifdef REGDUMP_CSUM_EN
      , CSUM
`endif
   } state_t;

endpackage

// File: rtl/regfile_dump_reader_csum.sv
// XOR accumulator over handshaked dump beats; only built with REGDUMP_CSUM_EN.
`ifdef REGDUMP_CSUM_EN
module regdump_csum
   import regdump_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] acc
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc ^ din;
      end
   end

endmodule
`endif

// File: rtl/regfile_dump_reader.sv
// Sweeps register indices FIRST_REG..LAST_REG through a spare read port and streams (idx, data) beats.
// Optional REGDUMP_CSUM_EN appends an XOR checksum beat at index 31.
module regfile_dump_reader
   import regdump_pkg::*;
#(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = NUM_REGS - 1,
   parameter int unsigned DATA_W    = DEF_DATA_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic [REG_IDX_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0]    rf_rdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [REG_IDX_W-1:0] out_idx,
   output logic [DATA_W-1:0]    out_data,
   output logic                 out_last
);

   localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
   localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

   if (LAST_REG < FIRST_REG || LAST_REG > NUM_REGS - 1) begin : g_param_check
      $error("regfile_dump_reader: need FIRST_REG <= LAST_REG <= 31");
   end

   state_t               state;
   logic [REG_IDX_W-1:0] idx;
   logic                 hs;

   assign hs       = out_valid & out_ready;
   assign busy     = (state != IDLE);
   assign done     = (state == FIN);
   assign rf_raddr = (state == READ) ? idx : '0;

`ifdef REGDUMP_CSUM_EN
   logic [DATA_W-1:0] csum_acc;

   regdump_csum #(.DATA_W(DATA_W)) u_csum (
      .clk (clk),
      .rst (rst),
      .clr ((state == IDLE) && start && !abort),
      .en  (hs && (state == SEND)),
      .din (out_data),
      .acc (csum_acc)
   );

   assign out_valid = (state == SEND) || (state == CSUM);
   assign out_last  = (state == CSUM);
`else
   assign out_valid = (state == SEND);
   assign out_last  = (state == SEND) && (idx == LAST_IDX);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= FIRST_IDX;
         out_idx  <= '0;
         out_data <= '0;
      end else if (abort && state != IDLE) begin
         state <= IDLE;
         idx   <= FIRST_IDX;
      end else begin
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  idx   <= FIRST_IDX;
                  state <= READ;
               end
            end
            READ: begin
               out_data <= rf_rdata;
               out_idx  <= idx;
               state    <= SEND;
            end
            SEND: begin
               if (hs) begin
                  if (idx == LAST_IDX) begin
`ifdef REGDUMP_CSUM_EN
                     // accumulator has not yet absorbed this last beat, so fold it in here
                     out_idx  <= REG_IDX_W'(NUM_REGS - 1);
                     out_data <= csum_acc ^ out_data;
                     state    <= CSUM;
`else
                     state <= FIN;
`endif
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= READ;
                  end
               end
            end
`ifdef REGDUMP_CSUM_EN
            CSUM: begin
               if (hs) begin
                  state <= FIN;
               end
            end
`endif
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench: two readers (full sweep and FIRST_REG=30) share one modelled register file.
module tb_regfile_dump_reader;
   import regdump_pkg::*;

   localparam int unsigned DW = 32;

   typedef struct packed {
      logic [4:0]    idx;
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic rst, start, abort, out_ready;
   logic [DW-1:0] rf [32];

   logic          a_busy, a_done, a_valid, a_last;
   logic [4:0]    a_raddr, a_idx;
   logic [DW-1:0] a_rdata, a_data;
   logic          b_busy, b_done, b_valid, b_last;
   logic [4:0]    b_raddr, b_idx;
   logic [DW-1:0] b_rdata, b_data;

   assign a_rdata = (a_raddr == 5'd0) ? '0 : rf[a_raddr];
   assign b_rdata = (b_raddr == 5'd0) ? '0 : rf[b_raddr];

   always #5 clk = ~clk;

   regfile_dump_reader dut_a (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(a_busy), .done(a_done),
      .rf_raddr(a_raddr), .rf_rdata(a_rdata), .out_valid(a_valid), .out_ready(out_ready),
      .out_idx(a_idx), .out_data(a_data), .out_last(a_last)
   );

   regfile_dump_reader #(.FIRST_REG(30), .LAST_REG(31), .DATA_W(DW)) dut_b (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(b_busy), .done(b_done),
      .rf_raddr(b_raddr), .rf_rdata(b_rdata), .out_valid(b_valid), .out_ready(out_ready),
      .out_idx(b_idx), .out_data(b_data), .out_last(b_last)
   );

   int checks = 0;
   int errors = 0;
   beat_t qa[$];
   beat_t qb[$];
   int pend_a = 0;
   int pend_b = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rdval(input int i);
      return (i == 0) ? '0 : rf[i];
   endfunction

   // Expected stream for one dump: every register in range in order, then the optional checksum.
   task automatic push_dump(input int which);
      int first;
      logic [DW-1:0] x;
      beat_t b;
      first = (which == 0) ? 0 : 30;
      x = '0;
      for (int i = first; i <= 31; i++) begin
         x ^= rdval(i);
         b.idx  = 5'(i);
         b.data = rdval(i);
`ifdef REGDUMP_CSUM_EN
         b.last = 1'b0;
`else
         b.last = (i == 31);
`endif
         if (which == 0) qa.push_back(b); else qb.push_back(b);
      end
`ifdef REGDUMP_CSUM_EN
      b.idx = 5'd31; b.data = x; b.last = 1'b1;
      if (which == 0) qa.push_back(b); else qb.push_back(b);
`endif
      if (which == 0) pend_a++; else pend_b++;
   endtask

   beat_t hold_a, hold_b;
   logic  held_a = 1'b0;
   logic  held_b = 1'b0;

   always @(negedge clk) begin
      beat_t cur, e;
      cur = {a_idx, a_data, a_last};
      if (!rst && !abort) begin
         if (held_a && a_valid) chk("A hold", 64'(cur), 64'(hold_a));
         if (a_valid && out_ready) begin
            if (qa.size() == 0) begin
               checks++; errors++;
               $display("FAIL A unexpected beat: got idx %0d, expected no beat", a_idx);
            end else begin
               e = qa.pop_front();
               chk("A beat", 64'(cur), 64'(e));
            end
         end
         if (a_done) begin
            checks++;
            if (pend_a == 0 || qa.size() != 0) begin
               errors++;
               $display("FAIL A done: pending %0d beats left %0d, expected pending>0 and 0 left", pend_a, qa.size());
            end else pend_a--;
         end
      end
      held_a = a_valid && !out_ready && !rst && !abort;
      hold_a = cur;
   end

   always @(negedge clk) begin
      beat_t cur, e;
      cur = {b_idx, b_data, b_last};
      if (!rst && !abort) begin
         if (held_b && b_valid) chk("B hold", 64'(cur), 64'(hold_b));
         if (b_valid && out_ready) begin
            if (qb.size() == 0) begin
               checks++; errors++;
               $display("FAIL B unexpected beat: got idx %0d, expected no beat", b_idx);
            end else begin
               e = qb.pop_front();
               chk("B beat", 64'(cur), 64'(e));
            end
         end
         if (b_done) begin
            checks++;
            if (pend_b == 0 || qb.size() != 0) begin
               errors++;
               $display("FAIL B done: pending %0d beats left %0d, expected pending>0 and 0 left", pend_b, qb.size());
            end else pend_b--;
         end
      end
      held_b = b_valid && !out_ready && !rst && !abort;
      hold_b = cur;
   end

   // mode 0: ready high, 1: random ready, 2: stall idx 3, 3: abort at idx 10, 4: reset at idx 7
   task automatic run_dump(input int mode, input bit timing);
      int cyc, first_v, done_a, done_b, stall;
      bit fin;
      cyc = 0; first_v = -1; done_a = -1; done_b = -1; stall = 0; fin = 1'b0;
      push_dump(0);
      push_dump(1);
      start = 1'b1;
      out_ready = 1'b1;
      while (!fin && cyc < 600) begin
         @(posedge clk); #1;
         cyc++;
         start = (cyc == 2);
         if (first_v < 0 && a_valid) first_v = cyc;
         if (done_a < 0 && a_done) done_a = cyc;
         if (done_b < 0 && b_done) done_b = cyc;
         out_ready = 1'b1;
         if (mode == 1) out_ready = 1'($urandom_range(0, 1));
         if (mode == 2 && a_valid && a_idx == 5'd3 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
         end
         if (mode == 3 && a_valid && a_idx == 5'd10) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            chk("abort busy/valid/done", 64'({a_busy, a_valid, a_done}), 64'(0));
            qa.delete();
            pend_a = 0;
            fin = 1'b1;
         end
         if (mode == 4 && a_valid && a_idx == 5'd7) begin
            rst = 1'b1;
            @(posedge clk); #1;
            chk("rst A outputs", 64'({a_busy, a_done, a_valid, a_last, a_idx, a_data, a_raddr}), 64'(0));
            chk("rst B outputs", 64'({b_busy, b_done, b_valid, b_last, b_idx, b_data, b_raddr}), 64'(0));
            rst = 1'b0;
            qa.delete(); qb.delete();
            pend_a = 0; pend_b = 0;
            fin = 1'b1;
         end
         if (done_a >= 0) fin = 1'b1;
      end
      start = 1'b0;
      if (!fin) begin
         checks++; errors++;
         $display("FAIL dump timeout: got no done in %0d cycles, expected done", cyc);
      end
      if (timing) begin
         chk("start to first valid", 64'(first_v), 64'(2));
`ifdef REGDUMP_CSUM_EN
         chk("A done cycle", 64'(done_a), 64'(66));
         chk("B done cycle", 64'(done_b), 64'(6));
`else
         chk("A done cycle", 64'(done_a), 64'(65));
         chk("B done cycle", 64'(done_b), 64'(5));
`endif
      end
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("drained", 64'({32'(qa.size()), 32'(qb.size())}), 64'(0));
      chk("no pending done", 64'({32'(pend_a), 32'(pend_b)}), 64'(0));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 32; i++) rf[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset A flags", 64'({a_busy, a_done, a_valid, a_last}), 64'(0));
      chk("reset A buses", 64'({a_idx, a_data, a_raddr}), 64'(0));
      chk("reset B outputs", 64'({b_busy, b_done, b_valid, b_last, b_idx, b_data, b_raddr}), 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // simultaneous start and abort in IDLE must not start a dump
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("start+abort idle", 64'({a_busy, b_busy}), 64'(0));

      rf[0] = 32'hFFFF0000;
      rf[1] = 32'h11111111;
      rf[5] = 32'hDEADBEEF;
      run_dump(0, 1'b1);
      run_dump(2, 1'b0);
      run_dump(3, 1'b0);
      run_dump(0, 1'b0);
      run_dump(4, 1'b0);

      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 32; i++) rf[i] = $urandom();
         run_dump(1, 1'b0);
      end

      for (int i = 0; i < 32; i++) rf[i] = '0;
      rf[1] = 32'hF0F0F0F0;
      rf[2] = 32'h0F0F0F0F;
      run_dump(0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
